// File: rtl/var_dump_pkg.sv
// -----------------------------------------------------------------------------
// var_dump_pkg
// Shared definitions for the variable-dump transmitter: FSM state encoding,
// the frame sync byte and the width of the LEN byte.
// Optional feature macro: VAR_DUMP_CSUM_EN adds the CSUM state to the enum.
// -----------------------------------------------------------------------------
package var_dump_pkg;

    localparam int         LEN_W     = 8;
    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_HDR  = 3'd1,
        ST_LEN  = 3'd2,
`ifdef VAR_DUMP_CSUM_EN
        ST_DATA = 3'd3,
        ST_CSUM = 3'd4
`else
        ST_DATA = 3'd3
`endif
    } state_e;

endpackage

// File: rtl/var_dump_csum.sv
// -----------------------------------------------------------------------------
// var_dump_csum
// Running XOR checksum over the bytes of one frame.
// Ports:
//   clk     - clock (rising edge)
//   rst_n   - asynchronous active-low reset, clears the checksum
//   clr_i   - restart the checksum (new frame captured)
//   acc_i   - fold data_i into the checksum on this edge
//   data_i  - byte being transferred
//   csum_o  - current checksum value
// Only instantiated when VAR_DUMP_CSUM_EN is defined.
// -----------------------------------------------------------------------------
module var_dump_csum
    import var_dump_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic             acc_i,
    input  logic [LEN_W-1:0] data_i,
    output logic [LEN_W-1:0] csum_o
);

    logic [LEN_W-1:0] csum_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            csum_q <= '0;
        end else if (clr_i) begin
            csum_q <= '0;
        end else if (acc_i) begin
            csum_q <= csum_q ^ data_i;
        end
    end

    assign csum_o = csum_q;

endmodule

// File: rtl/var_dump_tx.sv
// -----------------------------------------------------------------------------
// var_dump_tx
// Captures a snapshot of N_WORDS bytes on request and streams it out as a
// frame: 0xA5, LEN (= N_WORDS), data bytes 0..N_WORDS-1 [, XOR checksum].
// Optional feature macro: VAR_DUMP_CSUM_EN appends a checksum byte computed
// over LEN and all data bytes.
// Ports:
//   clk        - clock (rising edge)
//   rst_n      - asynchronous active-low reset, aborts any frame
//   snap_req   - capture snap_data and send one frame (ignored while busy)
//   snap_data  - snapshot image, byte k at [8k+7:8k]
//   out_valid  - out_data holds a frame byte
//   out_ready  - consumer accepts the byte
//   out_data   - current frame byte (0x00 when idle)
//   busy       - frame in progress
//   done       - one-cycle pulse after the final byte is accepted
//   overrun    - sticky: a request arrived while busy
//   state_o    - debug view of the FSM state
// Handshake: a byte moves on a rising edge where out_valid=1 and out_ready=1;
// while out_valid=1 and out_ready=0 the byte is held unchanged.
// -----------------------------------------------------------------------------
module var_dump_tx
    import var_dump_pkg::*;
#(
    parameter int N_WORDS = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 snap_req,
    input  logic [N_WORDS*8-1:0] snap_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [7:0]           out_data,
    output logic                 busy,
    output logic                 done,
    output logic                 overrun,
    output logic [2:0]           state_o
);

    localparam int               IDX_W    = $clog2(N_WORDS + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_WORDS - 1);
    localparam logic [LEN_W-1:0] LEN_BYTE = LEN_W'(N_WORDS);

    state_e                 state_q, state_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [N_WORDS*8-1:0]   shadow_q, shadow_d;
    logic                   overrun_q, overrun_d;
    logic                   done_q, done_d;

    logic       xfer;
    logic       accept;
    logic       drop;
    logic [7:0] data_byte;
    logic [7:0] out_byte;

    assign xfer   = (state_q != ST_IDLE) && out_ready;
    assign accept = snap_req && (state_q == ST_IDLE);
    // Any request outside IDLE is dropped, including one on the final edge.
    assign drop   = snap_req && (state_q != ST_IDLE);

`ifdef VAR_DUMP_CSUM_EN
    logic [7:0] csum_val;

    var_dump_csum u_csum (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (accept),
        .acc_i  (xfer && ((state_q == ST_LEN) || (state_q == ST_DATA))),
        .data_i (out_byte),
        .csum_o (csum_val)
    );
`endif

    // Select the shadow byte addressed by the index without out-of-range slices.
    always_comb begin
        data_byte = 8'h00;
        for (int k = 0; k < N_WORDS; k++) begin
            if (idx_q == IDX_W'(k)) begin
                data_byte = shadow_q[8*k +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            shadow_q  <= '0;
            overrun_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            shadow_q  <= shadow_d;
            overrun_q <= overrun_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        shadow_d  = shadow_q;
        done_d    = 1'b0;
        out_byte  = 8'h00;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    shadow_d = snap_data;
                    state_d  = ST_HDR;
                end
            end
            ST_HDR: begin
                out_byte = SYNC_BYTE;
                if (xfer) state_d = ST_LEN;
            end
            ST_LEN: begin
                out_byte = LEN_BYTE;
                if (xfer) begin
                    state_d = ST_DATA;
                    idx_d   = '0;
                end
            end
            ST_DATA: begin
                out_byte = data_byte;
                if (xfer) begin
                    if (idx_q == LAST_IDX) begin
`ifdef VAR_DUMP_CSUM_EN
                        state_d = ST_CSUM;
`else
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
`endif
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
`ifdef VAR_DUMP_CSUM_EN
            ST_CSUM: begin
                out_byte = csum_val;
                if (xfer) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase

        // A drop sets overrun even if an accept would clear it.
        overrun_d = overrun_q;
        if (drop) begin
            overrun_d = 1'b1;
        end else if (accept) begin
            overrun_d = 1'b0;
        end
    end

    assign out_valid = (state_q != ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign out_data  = out_byte;
    assign done      = done_q;
    assign overrun   = overrun_q;
    assign state_o   = state_q;

endmodule
